fht_unload: RTL and testbench



---
 rtl/fht_unload.sv | 177 +++++++++++++++++
 tb/tb_fht_unload.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_unload.sv
// fht_unload: streams the FHT result RAM (four banks, one group of four
// words per address) out as a single valid/ready word stream.
//
// Sequence: IDLE -> FETCH (address 0 presented) -> LOAD (bank data arrives,
// buffer captured) -> STREAM (one word per transfer, b = 0..3 per group).
// The next group is prefetched on the transfer of word 0 so that the buffer
// can reload on the transfer of word 3 without a bubble.
//
// Optional feature: define UNLOAD_BITREV_EN to report oINDEX bit-reversed
// over A_BIT+2 bits (natural spectrum order after the bit-reversed FHT).
// Without it oINDEX = 4*g + b. Data order and timing are identical.

module fht_unload #(
    parameter int D_BIT = 16,
    parameter int A_BIT = 8
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic               iFHT_RDY,
    output logic [A_BIT-1:0]   oADDR_RD_0,
    output logic [A_BIT-1:0]   oADDR_RD_1,
    output logic [A_BIT-1:0]   oADDR_RD_2,
    output logic [A_BIT-1:0]   oADDR_RD_3,
    input  logic [D_BIT-1:0]   iDATA_0,
    input  logic [D_BIT-1:0]   iDATA_1,
    input  logic [D_BIT-1:0]   iDATA_2,
    input  logic [D_BIT-1:0]   iDATA_3,
    output logic [D_BIT-1:0]   oDATA,
    output logic [A_BIT+1:0]   oINDEX,
    output logic               oVALID,
    input  logic               iREADY,
    output logic               oLAST,
    output logic               oBUSY,
    output logic               oDONE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_LOAD   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    localparam logic [A_BIT-1:0] G_LAST = '1;
    localparam logic [A_BIT-1:0] G_ONE  = 1;

    state_t           state_q;
    state_t           state_d;

    logic [A_BIT-1:0] grp_q;     // group whose words sit in the buffer
    logic [A_BIT-1:0] addr_q;    // group currently addressed in the RAM
    logic [1:0]       word_q;    // bank index b of the word on oDATA
    logic [D_BIT-1:0] buf_q [4];
    logic             done_q;

    logic             xfer;
    logic             abort;
    logic             last_word;

    assign xfer      = (state_q == S_STREAM) && iREADY;
    assign abort     = (state_q != S_IDLE) && !iFHT_RDY;
    assign last_word = (grp_q == G_LAST) && (word_q == 2'd3);

    // State register.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update from the same pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Next-state logic; losing iFHT_RDY aborts from any active state and
    // wins over a simultaneous final transfer.
    always_comb begin
        // NOTE: default first so that no path through the case leaves
        // state_d unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (iSTART && iFHT_RDY) state_d = S_FETCH;
            S_FETCH:  state_d = iFHT_RDY ? S_LOAD : S_IDLE;
            S_LOAD:   state_d = iFHT_RDY ? S_STREAM : S_IDLE;
            S_STREAM: begin
                if (abort)                 state_d = S_IDLE;
                else if (xfer && last_word) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        oVALID = 1'b0;
        oBUSY  = 1'b0;
        oLAST  = 1'b0;
        case (state_q)
            S_FETCH, S_LOAD: oBUSY = 1'b1;
            S_STREAM: begin
                oBUSY  = 1'b1;
                oVALID = 1'b1;
                oLAST  = last_word;
            end
            default: ;
        endcase
    end

    // Group/word counters, prefetch address and the four-word buffer.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            grp_q  <= '0;
            addr_q <= '0;
            word_q <= 2'd0;
            // NOTE: the buffer is only four words, so it is reset explicitly;
            // that keeps oDATA at zero during reset without extra gating.
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else if (state_d == S_IDLE) begin
            // Returning to (or staying in) IDLE rewinds to group 0 so the
            // next FETCH presents address 0.
            grp_q  <= '0;
            addr_q <= '0;
            word_q <= 2'd0;
        end else begin
            if (state_q == S_LOAD) begin
                buf_q[0] <= iDATA_0;
                buf_q[1] <= iDATA_1;
                buf_q[2] <= iDATA_2;
                buf_q[3] <= iDATA_3;
            end
            if (xfer) begin
                word_q <= word_q + 2'd1;
                if (word_q == 2'd0) begin
                    // Prefetch the next group; saturate on the last one.
                    addr_q <= (grp_q == G_LAST) ? grp_q : grp_q + G_ONE;
                end
                if (word_q == 2'd3) begin
                    buf_q[0] <= iDATA_0;
                    buf_q[1] <= iDATA_1;
                    buf_q[2] <= iDATA_2;
                    buf_q[3] <= iDATA_3;
                    grp_q    <= grp_q + G_ONE;
                end
            end
        end
    end

    // One-cycle completion pulse after an un-aborted final transfer.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && iFHT_RDY && last_word;
        end
    end

`ifdef UNLOAD_BITREV_EN
    function automatic logic [A_BIT+1:0] bit_reverse(input logic [A_BIT+1:0] v);
        logic [A_BIT+1:0] r;
        for (int i = 0; i < A_BIT + 2; i++) r[i] = v[A_BIT+1-i];
        return r;
    endfunction

    assign oINDEX = bit_reverse({grp_q, word_q});
`else
    assign oINDEX = {grp_q, word_q};
`endif

    assign oDATA      = buf_q[word_q];
    assign oDONE      = done_q;
    assign oADDR_RD_0 = addr_q;
    assign oADDR_RD_1 = addr_q;
    assign oADDR_RD_2 = addr_q;
    assign oADDR_RD_3 = addr_q;

endmodule

// File: tb/tb_fht_unload.sv
// Directed bench for fht_unload with A_BIT=2 (N=16). Bank b at address a
// holds 16*b + a, modelled as a registered RAM with one cycle read latency.
// Word k of the stream (k = 4*g + b) must carry 16*(k%4) + k/4.

module tb_fht_unload;

    localparam int D_BIT = 16;
    localparam int A_BIT = 2;
    localparam int N     = 16;

    logic             iCLK;
    logic             iRESET;
    logic             iSTART;
    logic             iFHT_RDY;
    logic [A_BIT-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
    logic [D_BIT-1:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3;
    logic [D_BIT-1:0] oDATA;
    logic [A_BIT+1:0] oINDEX;
    logic             oVALID;
    logic             iREADY;
    logic             oLAST;
    logic             oBUSY;
    logic             oDONE;

    int n_checks = 0;
    int n_errors = 0;

    fht_unload #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iSTART     (iSTART),
        .iFHT_RDY   (iFHT_RDY),
        .oADDR_RD_0 (oADDR_RD_0),
        .oADDR_RD_1 (oADDR_RD_1),
        .oADDR_RD_2 (oADDR_RD_2),
        .oADDR_RD_3 (oADDR_RD_3),
        .iDATA_0    (iDATA_0),
        .iDATA_1    (iDATA_1),
        .iDATA_2    (iDATA_2),
        .iDATA_3    (iDATA_3),
        .oDATA      (oDATA),
        .oINDEX     (oINDEX),
        .oVALID     (oVALID),
        .iREADY     (iREADY),
        .oLAST      (oLAST),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Registered result RAM: bank b returns 16*b + address one cycle later.
    always @(posedge iCLK) begin
        iDATA_0 <= 16'd0  + {14'd0, oADDR_RD_0};
        iDATA_1 <= 16'd16 + {14'd0, oADDR_RD_1};
        iDATA_2 <= 16'd32 + {14'd0, oADDR_RD_2};
        iDATA_3 <= 16'd48 + {14'd0, oADDR_RD_3};
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [3:0] exp_index(input int k);
        logic [3:0] v;
        logic [3:0] r;
        v = 4'(k);
`ifdef UNLOAD_BITREV_EN
        r = {v[0], v[1], v[2], v[3]};
`else
        r = v;
`endif
        return r;
    endfunction

    // Pulse iSTART and check the FETCH/LOAD latency (valid must still be low).
    task automatic start_unload();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        n_checks++;
        if (oBUSY !== 1'b1 || oVALID !== 1'b0) begin
            n_errors++;
            $display("FAIL start_fetch: busy=%b valid=%b, need busy=1 valid=0", oBUSY, oVALID);
        end
        tick();
        n_checks++;
        if (oBUSY !== 1'b1 || oVALID !== 1'b0) begin
            n_errors++;
            $display("FAIL start_load: busy=%b valid=%b, need busy=1 valid=0", oBUSY, oVALID);
        end
        tick();
    endtask

    // Accept n_words words, checking every cycle; toggle gives ready 1,0,1,0.
    task automatic drain_stream(input bit toggle, input int n_words, input bit hold_start);
        int  k   = 0;
        int  cyc = 0;
        bit  xfer;
        logic [15:0] exp_d;
        while (k < n_words && cyc < 200) begin
            iREADY = toggle ? (cyc % 2 == 0) : 1'b1;
            iSTART = hold_start && (k < N - 1);
            exp_d  = 16'(16 * (k % 4) + k / 4);
            n_checks++;
            if (oVALID !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_valid word %0d: valid=%b, need 1", k, oVALID);
            end
            n_checks++;
            if (oDATA !== exp_d || oINDEX !== exp_index(k) || oLAST !== (k == N - 1) || oDONE !== 1'b0) begin
                n_errors++;
                $display("FAIL stream_word %0d: data=%0d idx=%0d last=%b done=%b, need data=%0d idx=%0d last=%b done=0",
                         k, oDATA, oINDEX, oLAST, oDONE, exp_d, exp_index(k), (k == N - 1));
            end
            xfer = iREADY;
            tick();
            if (xfer) k++;
            cyc++;
        end
        iSTART = 1'b0;
        iREADY = 1'b1;
        n_checks++;
        if (k != n_words) begin
            n_errors++;
            $display("FAIL stream_timeout: words=%0d, need %0d", k, n_words);
        end
    endtask

    task automatic check_done_pulse();
        n_checks++;
        if (oDONE !== 1'b1 || oVALID !== 1'b0 || oBUSY !== 1'b0 || oLAST !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b last=%b, need 1 0 0 0", oDONE, oVALID, oBUSY, oLAST);
        end
        tick();
        n_checks++;
        if (oDONE !== 1'b0 || oBUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL done_single: done=%b busy=%b, need 0 0", oDONE, oBUSY);
        end
    endtask

    task automatic test_reset();
        iRESET   = 1'b0;
        iSTART   = 1'b0;
        iFHT_RDY = 1'b1;
        iREADY   = 1'b1;
        #12;
        n_checks++;
        if ({oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: addr=%0d data=%0d idx=%0d valid=%b last=%b busy=%b done=%b, need all 0",
                     oADDR_RD_0, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE);
        end
        @(negedge iCLK);
        iRESET = 1'b1;
        tick();
        n_checks++;
        if (oBUSY !== 1'b0 || oVALID !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b valid=%b, need 0 0", oBUSY, oVALID);
        end
    endtask

    task automatic test_stream();
        start_unload();
        drain_stream(1'b0, N, 1'b0);
        check_done_pulse();
    endtask

    task automatic test_backpressure();
        start_unload();
        drain_stream(1'b1, N, 1'b0);
        check_done_pulse();
    endtask

    task automatic test_ignored_start();
        iFHT_RDY = 1'b0;
        iSTART   = 1'b1;
        tick();
        iSTART   = 1'b0;
        n_checks++;
        if (oBUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL start_not_ready: busy=%b, need 0", oBUSY);
        end
        iFHT_RDY = 1'b1;
        tick();
        n_checks++;
        if (oBUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL start_not_ready_later: busy=%b, need 0", oBUSY);
        end
        start_unload();
        drain_stream(1'b0, N, 1'b1);
        check_done_pulse();
    endtask

    task automatic test_abort();
        start_unload();
        drain_stream(1'b0, 5, 1'b0);
        iFHT_RDY = 1'b0;
        tick();
        n_checks++;
        if (oVALID !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_outputs: valid=%b busy=%b done=%b, need 0 0 0", oVALID, oBUSY, oDONE);
        end
        tick();
        n_checks++;
        if (oDONE !== 1'b0 || oBUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_no_done: done=%b busy=%b, need 0 0", oDONE, oBUSY);
        end
        iFHT_RDY = 1'b1;
        start_unload();
        drain_stream(1'b0, N, 1'b0);
        check_done_pulse();
    endtask

    task automatic test_async_reset();
        start_unload();
        drain_stream(1'b0, 3, 1'b0);
        #3;
        iRESET = 1'b0;
        #1;
        n_checks++;
        if ({oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: addr=%0d data=%0d idx=%0d valid=%b last=%b busy=%b done=%b, need all 0",
                     oADDR_RD_0, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE);
        end
        @(negedge iCLK);
        iRESET = 1'b1;
        tick();
        tick();
        n_checks++;
        if (oBUSY !== 1'b0 || oVALID !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_needs_start: busy=%b valid=%b, need 0 0", oBUSY, oVALID);
        end
        start_unload();
        drain_stream(1'b0, N, 1'b0);
        check_done_pulse();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_ignored_start();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
